// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM encoding and digit helper for the serial BCD adder
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational one-digit BCD adder with decimal carry
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a4,
  input  logic [DIGIT_W-1:0] b4,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s4,
  output logic               co
);

  logic [DIGIT_W:0] t;

  always_comb begin
    t  = {1'b0, a4} + {1'b0, b4} + {{DIGIT_W{1'b0}}, ci};
    s4 = t[DIGIT_W-1:0];
    co = 1'b0;
    // Past 9 the binary sum skips the six unused codes to wrap back into 0..9.
    if (t > (DIGIT_W + 1)'(BCD_MAX)) begin
      s4 = t[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial BCD add sequencer; BCD_DIGIT_CHECK_EN enables invalid-digit flag
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q, cout_q, accept;
  logic [DIGIT_W-1:0] da, db, ds;
  logic               dco;

  assign da = a_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
  assign db = b_q[DIGIT_W*int'(idx_q) +: DIGIT_W];

  bcd_digit_add u_digit_add (
    .a4 (da),
    .b4 (db),
    .ci (carry_q),
    .s4 (ds),
    .co (dco)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        idx_q   <= '0;
      end
      // sum is rewritten digit by digit; untouched digits keep the previous result.
      if (state_q == RUN) begin
        sum_q[DIGIT_W*int'(idx_q) +: DIGIT_W] <= ds;
        carry_q <= dco;
        idx_q   <= idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) cout_q <= dco;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_in = bad_in | digit_invalid(a[DIGIT_W*i +: DIGIT_W])
                      | digit_invalid(b[DIGIT_W*i +: DIGIT_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept) err_q <= bad_in;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - self-checking bench for bcd_serial_add_ctrl against a decimal reference model
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_bad(input logic [W-1:0] x, input logic [W-1:0] y);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // Valid operands: plain decimal addition. Invalid digits: the digit-wise rule with integers.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int s, lim, c, t, p;
    logic [W-1:0] r;
    r = '0;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    if (!any_bad(x, y)) begin
      s = int'(ci);
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        s = s + (int'(x[4*i +: 4]) + int'(y[4*i +: 4])) * p;
        p = p * 10;
      end
      c = (s >= lim) ? 1 : 0;
      s = s % lim;
      for (int i = 0; i < DIGITS; i++) begin
        r[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < DIGITS; i++) begin
        t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
        if (t > 9) begin
          r[4*i +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          r[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
    end
    return {c[0], r};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic logic exp_err_of(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef BCD_DIGIT_CHECK_EN
    return any_bad(x, y);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with the DUT idle. Done must appear DIGITS edges after the accepting edge,
  // i.e. at the (DIGITS+1)th negedge after start is driven.
  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    logic [W:0] exp;
    int n;
    exp = ref_add(oa, ob, oc);
    a = oa;
    b = ob;
    cin = oc;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 20);
    check({tag, "/latency"}, 32'(n), 32'(DIGITS + 1));
    check({tag, "/sum"}, 32'(sum), 32'(exp[W-1:0]));
    check({tag, "/cout"}, 32'(cout), 32'(exp[W]));
    check({tag, "/err"}, 32'(err), 32'(exp_err_of(oa, ob)));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd1);
    a = W'($urandom);
    b = W'($urandom);
    @(negedge clk);
    check({tag, "/busy_after"}, 32'(busy), 32'd0);
    check({tag, "/done_after"}, 32'(done), 32'd0);
    check({tag, "/sum_held"}, 32'(sum), 32'(exp[W-1:0]));
  endtask

  logic [W-1:0] ha [0:40];
  logic [W-1:0] hb [0:40];
  logic         hc [0:40];
  logic [W:0]   e4;
  int           last_done, ndone;
  logic         saw_done;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/sum", 32'(sum), 32'd0);
    check("rst/cout", 32'(cout), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, expectations also pinned as constants
    run_op("t1", 16'h1234, 16'h5678, 1'b0);
    check("t1/const", 32'(sum), 32'h6912);
    run_op("t2", 16'h9999, 16'h0001, 1'b0);
    check("t2/const", 32'({cout, sum}), 32'h1_0000);
    run_op("t3a", 16'h0000, 16'h0000, 1'b1);
    check("t3a/const", 32'({cout, sum}), 32'h0_0001);
    run_op("t3b", 16'h9999, 16'h9999, 1'b1);
    check("t3b/const", 32'({cout, sum}), 32'h1_9999);

    // Random valid operands
    for (int i = 0; i < 12; i++)
      run_op("rnd", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));

    // start held high with operands changing every cycle: one accept per DIGITS+2 cycles
    last_done = -1;
    ndone = 0;
    ha[0] = rand_bcd();
    hb[0] = rand_bcd();
    hc[0] = 1'($urandom_range(0, 1));
    a = ha[0];
    b = hb[0];
    cin = hc[0];
    start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done) begin
        e4 = ref_add(ha[c-DIGITS-1], hb[c-DIGITS-1], hc[c-DIGITS-1]);
        check("t4/sum", 32'(sum), 32'(e4[W-1:0]));
        check("t4/cout", 32'(cout), 32'(e4[W]));
        if (last_done >= 0) check("t4/gap", 32'(c - last_done), 32'(DIGITS + 2));
        last_done = c;
        ndone++;
      end
      ha[c] = rand_bcd();
      hb[c] = rand_bcd();
      hc[c] = 1'($urandom_range(0, 1));
      a = ha[c];
      b = hb[c];
      cin = hc[c];
    end
    start = 1'b0;
    check("t4/done_count", 32'(ndone), 32'd6);
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of RUN
    run_op("t5pre", 16'h1234, 16'h5678, 1'b0);
    a = 16'h4321;
    b = 16'h1111;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5/busy", 32'(busy), 32'd0);
    check("t5/done", 32'(done), 32'd0);
    check("t5/sum", 32'(sum), 32'd0);
    check("t5/cout", 32'(cout), 32'd0);
    check("t5/err", 32'(err), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("t5/no_done", 32'(saw_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t5post", 16'h0456, 16'h0789, 1'b1);

    // Invalid digit: err only when checking is built in; sum follows the digit rule either way
    run_op("t6bad", 16'h12A4, 16'h0001, 1'b0);
    run_op("t6good", 16'h1111, 16'h2222, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
